// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl: raster-scan read controller for a synchronous image ROM with latency-aligned pixel markers
module rom_scan_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int ADDR_W = 15,
  parameter int CNT_W = 8,
  parameter int RD_LAT = 1,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              out_ready,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              pix_valid,
  output logic [CNT_W-1:0]  pix_col,
  output logic [CNT_W-1:0]  pix_row,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              frame_done,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
  localparam int DW = 2 * CNT_W + 3;
  state_t state, state_nxt;
  logic [CNT_W-1:0] col, row;
  logic [ADDR_W-1:0] addr;
  logic [2:0] dcnt;
  logic [DW-1:0] iss;
  logic [RD_LAT-1:0] dv;
  logic [DW-1:0] dl [RD_LAT];
  logic issue, last_col, last_pix;
  assign last_col = col == LAST_COL;
  assign last_pix = last_col && row == LAST_ROW;
  assign issue = state == SCAN && out_ready && !stop;
  assign pix_valid = dv[RD_LAT-1];
  assign {pix_row, pix_col} = dl[RD_LAT-1][DW-1:3];
  assign sof = pix_valid & dl[RD_LAT-1][2];
  assign eol = pix_valid & dl[RD_LAT-1][1];
  assign eof = pix_valid & dl[RD_LAT-1][0];
  assign frame_done = eof;
  assign busy = state != IDLE;
  // next state: stop aborts from anywhere, drain lasts exactly RD_LAT cycles
  always_comb begin
    state_nxt = state;
    state_nxt = stop ? IDLE :
                (state == IDLE && start) ? SCAN :
                (issue && last_pix && !CONTINUOUS) ? DRAIN :
                (state == DRAIN && dcnt == 3'(RD_LAT - 1)) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  // raster counters, registered read strobe and the free-running latency delay line
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      col <= '0;
      row <= '0;
      addr <= '0;
      rom_rd_en <= 1'b0;
      rom_addr <= '0;
      iss <= '0;
      dv <= '0;
      dcnt <= '0;
      for (int i = 0; i < RD_LAT; i++) dl[i] <= '0;
    end else begin
      rom_rd_en <= issue;
      dcnt <= state == DRAIN ? dcnt + 3'd1 : 3'd0;
      dv <= stop ? '0 : RD_LAT'({dv, rom_rd_en});
      dl[0] <= iss;
      for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
      if (stop) begin
        col <= '0;
        row <= '0;
        addr <= '0;
        rom_addr <= '0;
      end else if (issue) begin
        rom_addr <= addr;
        iss <= {row, col, row == '0 && col == '0, last_col, last_pix};
        col <= last_col ? '0 : col + 1'b1;
        row <= last_pix ? '0 : last_col ? row + 1'b1 : row;
        addr <= last_pix ? '0 : addr + 1'b1;
      end
    end
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// tb_rom_scan_ctrl: scenario bench for rom_scan_ctrl against a transaction-level raster model
module tb_rom_scan_ctrl;
  localparam int W = 4, H = 3, N = W * H, AW = 4, CW = 2;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, stop = 1'b0, out_ready = 1'b0;
  logic rd [3], pv [3], so [3], eo [3], ef [3], fd [3], bsy [3];
  logic [AW-1:0] ad [3];
  logic [CW-1:0] pc [3], pr [3];
  int n_cmp = 0, n_err = 0, cyc = 0;
  bit p_start, p_stop, p_ready;
  bit m_busy [3], m_ok [3], m_pend [3];
  int m_next [3], rcnt [3], fcnt [3], scnt [3];
  int q [3][$];

  always #5 clk = ~clk;

  // dut 0: latency 1 single-shot, dut 1: latency 2 single-shot, dut 2: latency 1 continuous
  for (genvar g = 0; g < 3; g++) begin : u
    rom_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CNT_W(CW),
                    .RD_LAT(g == 1 ? 2 : 1), .CONTINUOUS(g == 2)) dut (
      .clk(clk), .rstn(rstn), .start(start), .stop(stop), .out_ready(out_ready),
      .rom_rd_en(rd[g]), .rom_addr(ad[g]), .pix_valid(pv[g]), .pix_col(pc[g]),
      .pix_row(pr[g]), .sof(so[g]), .eol(eo[g]), .eof(ef[g]),
      .frame_done(fd[g]), .busy(bsy[g]));
  end

  function automatic logic [14:0] outs(int d);
    return {rd[d], ad[d], pv[d], pc[d], pr[d], so[d], eo[d], ef[d], fd[d], bsy[d]};
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      m_busy[d] = 0; m_ok[d] = 0; m_pend[d] = 0; m_next[d] = 0;
      rcnt[d] = 0; fcnt[d] = 0; scnt[d] = 0; q[d].delete();
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) begin rcnt[d] = 0; fcnt[d] = 0; scnt[d] = 0; end
  endtask

  // one clock: capture inputs at the edge, then score every dut at the falling edge
  task automatic tick();
    int lat, a;
    bit ev, er;
    logic [2*CW+3:0] got, want;
    @(posedge clk);
    p_start = start; p_stop = stop; p_ready = out_ready; cyc++;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      lat = d == 1 ? 2 : 1;
      if (p_stop) begin
        m_busy[d] = 0; m_ok[d] = 0; m_pend[d] = 0; m_next[d] = 0; q[d].delete();
      end else begin
        if (m_pend[d]) begin m_ok[d] = 1; m_pend[d] = 0; end
        if (p_start && !m_busy[d]) begin m_busy[d] = 1; m_pend[d] = 1; m_next[d] = 0; end
      end
      ev = q[d].size() > 0 && q[d][0] / 16 + lat == cyc;
      n_cmp++;
      if (pv[d] !== ev) begin
        n_err++; $display("FAIL pix_valid d%0d cyc %0d: got %b want %b", d, cyc, pv[d], ev);
      end
      got = {pr[d], pc[d], so[d], eo[d], ef[d], fd[d]};
      if (ev) begin
        a = q[d].pop_front() % 16;
        want = {CW'(a / W), CW'(a % W), a == 0, a % W == W - 1, a == N - 1, a == N - 1};
        if (a == 0) scnt[d]++;
        if (a == N - 1) begin fcnt[d]++; if (d != 2) m_busy[d] = 0; end
      end else want = {pr[d], pc[d], 4'b0000};
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL pixel d%0d cyc %0d: got %h want %h", d, cyc, got, want);
      end
      er = p_ready && m_ok[d];
      n_cmp++;
      if (rd[d] !== er) begin
        n_err++; $display("FAIL rom_rd_en d%0d cyc %0d: got %b want %b", d, cyc, rd[d], er);
      end
      if (rd[d] === 1'b1) begin
        rcnt[d]++;
        n_cmp++;
        if (ad[d] !== AW'(m_next[d])) begin
          n_err++; $display("FAIL rom_addr d%0d cyc %0d: got %0d want %0d", d, cyc, ad[d], m_next[d]);
        end
        q[d].push_back(cyc * 16 + m_next[d]);
        if (m_next[d] == N - 1 && d != 2) m_ok[d] = 0;
        m_next[d] = (m_next[d] + 1) % N;
      end
      n_cmp++;
      if (bsy[d] !== m_busy[d]) begin
        n_err++; $display("FAIL busy d%0d cyc %0d: got %b want %b", d, cyc, bsy[d], m_busy[d]);
      end
    end
  endtask

  task automatic abort();
    stop = 1; tick(); stop = 0; out_ready = 0; tick();
  endtask

  task automatic wait_single_done();
    for (int i = 0; i < 80 && !(fcnt[0] == 1 && fcnt[1] == 1); i++) tick();
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rcnt[d] !== 12 || fcnt[d] !== 1 || bsy[d] !== 1'b0) begin
        n_err++;
        $display("FAIL frame_totals d%0d: reads %0d frames %0d busy %b want 12 1 0", d, rcnt[d], fcnt[d], bsy[d]);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    #12;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (outs(d) !== 15'd0) begin
        n_err++; $display("FAIL reset_outputs d%0d: got %h want 0", d, outs(d));
      end
    end
    @(negedge clk); rstn = 1; model_clear();
    tick();
  endtask

  task automatic test_frame();
    clear_counts();
    out_ready = 1; start = 1; tick(); start = 0;
    wait_single_done();
    abort();
  endtask

  task automatic test_stall();
    bit seen = 0;
    clear_counts();
    out_ready = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = rd[0] === 1'b1 && ad[0] === 4'd4; end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL stall_reach: addr 4 never read, want read"); end
    out_ready = 0;
    repeat (3) tick();
    out_ready = 1; tick();
    n_cmp++;
    if (rd[0] !== 1'b1 || ad[0] !== 4'd5) begin
      n_err++; $display("FAIL stall_resume: rd %b addr %0d want 1 5", rd[0], ad[0]);
    end
    wait_single_done();
    abort();
  endtask

  task automatic test_continuous();
    clear_counts();
    out_ready = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 80 && fcnt[2] < 2; i++) tick();
    n_cmp++;
    if (fcnt[2] !== 2 || scnt[2] !== 2 || bsy[2] !== 1'b1) begin
      n_err++; $display("FAIL continuous: frames %0d sofs %0d busy %b want 2 2 1", fcnt[2], scnt[2], bsy[2]);
    end
    abort();
  endtask

  task automatic test_stop();
    bit seen = 0;
    clear_counts();
    out_ready = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = rd[0] === 1'b1 && ad[0] === 4'd6; end
    stop = 1; tick(); stop = 0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (!seen || rd[d] !== 1'b0 || bsy[d] !== 1'b0) begin
        n_err++; $display("FAIL stop d%0d: seen %b rd %b busy %b want 1 0 0", d, seen, rd[d], bsy[d]);
      end
    end
    repeat (5) tick();
    n_cmp++;
    if (fcnt[0] + fcnt[1] + fcnt[2] !== 0) begin
      n_err++; $display("FAIL stop_no_eof: frames %0d want 0", fcnt[0] + fcnt[1] + fcnt[2]);
    end
    start = 1; tick(); start = 0; tick();
    n_cmp++;
    if (rd[0] !== 1'b1 || ad[0] !== 4'd0) begin
      n_err++; $display("FAIL restart: rd %b addr %0d want 1 0", rd[0], ad[0]);
    end
    abort();
  endtask

  task automatic test_ignore();
    clear_counts();
    out_ready = 1; start = 1; stop = 1; tick(); start = 0; stop = 0; tick();
    n_cmp++;
    if (bsy[0] !== 1'b0 || bsy[1] !== 1'b0 || bsy[2] !== 1'b0 || rcnt[0] !== 0) begin
      n_err++; $display("FAIL start_stop: busy %b%b%b reads %0d want 000 0", bsy[0], bsy[1], bsy[2], rcnt[0]);
    end
    start = 1; tick(); start = 0;
    repeat (3) tick();
    start = 1; tick(); start = 0;
    wait_single_done();
    abort();
  endtask

  task automatic test_reset_mid();
    out_ready = 1; start = 1; tick(); start = 0;
    repeat (5) tick();
    #2 rstn = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (outs(d) !== 15'd0) begin
        n_err++; $display("FAIL reset_mid d%0d: got %h want 0", d, outs(d));
      end
    end
    out_ready = 0;
    @(posedge clk); @(negedge clk);
    rstn = 1; model_clear();
    tick();
  endtask

  task automatic test_random();
    clear_counts();
    for (int i = 0; i < 400; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      start = $urandom_range(0, 9) == 0;
      stop = $urandom_range(0, 59) == 0;
      tick();
    end
    start = 0; stop = 0;
    n_cmp++;
    if (rcnt[0] == 0) begin n_err++; $display("FAIL random_activity: reads %0d want >0", rcnt[0]); end
    abort();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_continuous();
    test_stop();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
